playback_rate_engine: RTL and testbench

//   Sample-rate playback engine for the SRAM recorder. On each DAC frame tick it

---
 rtl/playback_rate_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_playback_rate_engine.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_rate_engine.sv
// Variable-rate playback of recorded SRAM samples, one output per DAC frame tick.
// Fast mode skips source samples, slow mode repeats them with optional linear interpolation.
module playback_rate_engine #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int SPD_W  = 4
) (
  input  logic              clk50_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              fast_i,
  input  logic [SPD_W-1:0]  speed_i,
  input  logic              interp_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  input  logic              sample_tick_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] out_sample_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o
);

  localparam int DIV_W = DATA_W + SPD_W + 1;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_RD0, S_RD1, S_DIV, S_CALC} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     i_q, i_d, next_i;
  logic [SPD_W-1:0]    j_q, j_d, n_q, n_d, rem_q, rem_d;
  logic                fast_q, fast_d, interp_q, interp_d, neg_q, neg_d;
  logic [DATA_W-1:0]   s0_q, s0_d, s1_q, s1_d, out_sample_q, out_sample_d;
  logic                out_valid_q, out_valid_d, done_q, done_d;
  logic                underrun_q, underrun_d, mem_req_q, mem_req_d;
  logic                end_pend_q, end_pend_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DIV_W-1:0]    quo_q, quo_d, quo_s, sum;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_div, slow_interp;
  logic [DATA_W:0]     delta;
  logic signed [DIV_W-1:0] prod;
  logic [SPD_W:0]      trial, rem_tmp;

  assign slow_interp = !fast_q && interp_q;

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    n_d          = n_q;
    fast_d       = fast_q;
    interp_d     = interp_q;
    neg_d        = neg_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    underrun_d   = underrun_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    end_pend_d   = end_pend_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    load_div     = 1'b0;
    next_i       = i_q;
    quo_s        = '0;
    sum          = '0;
    delta        = '0;
    prod         = '0;
    trial        = '0;
    rem_tmp      = '0;

    unique case (state_q)
      S_IDLE: ;
      S_PLAY: begin
        if (end_pend_q) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          i_d        = '0;
          j_d        = '0;
          end_pend_d = 1'b0;
        end else if (pause_i) begin
          out_sample_d = '0;
        end else if (sample_tick_i) begin
          state_d = S_RD0;
          // Mode only changes on a source-sample boundary
          if (j_q == '0) begin
            fast_d     = fast_i;
            interp_d   = interp_i;
            n_d        = (speed_i == '0) ? SPD_W'(1) : speed_i;
            mem_req_d  = 1'b1;
            mem_addr_d = i_q[ADDR_W-1:0];
          end
        end
      end
      S_RD0: begin
        if (j_q != '0) begin
          if (slow_interp) begin
            load_div = 1'b1;
            state_d  = S_DIV;
          end else begin
            state_d = S_CALC;
          end
        end else if (mem_ack_i) begin
          s0_d      = mem_data_i;
          mem_req_d = 1'b0;
          if (!slow_interp) begin
            state_d = S_CALC;
          end else if (i_q == {1'b0, end_addr_i}) begin
            s1_d     = mem_data_i;
            load_div = 1'b1;
            state_d  = S_DIV;
          end else begin
            state_d = S_RD1;
          end
        end
      end
      S_RD1: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = i_q[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (mem_ack_i) begin
          s1_d      = mem_data_i;
          mem_req_d = 1'b0;
          load_div  = 1'b1;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        trial = {rem_q, quo_q[DIV_W-1]};
        if (trial >= {1'b0, n_q}) begin
          rem_tmp = trial - {1'b0, n_q};
          rem_d   = rem_tmp[SPD_W-1:0];
          quo_d   = {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d = trial[SPD_W-1:0];
          quo_d = {quo_q[DIV_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_W - 1)) state_d = S_CALC;
      end
      S_CALC: begin
        if (slow_interp) begin
          quo_s        = neg_q ? -quo_q : quo_q;
          sum          = DIV_W'($signed(s0_q)) + quo_s;
          out_sample_d = sum[DATA_W-1:0];
        end else begin
          out_sample_d = s0_q;
        end
        out_valid_d = 1'b1;
        if (fast_q) begin
          next_i = i_q + {{(ADDR_W+1-SPD_W){1'b0}}, n_q};
          j_d    = '0;
        end else if (j_q == n_q - SPD_W'(1)) begin
          next_i = i_q + {{ADDR_W{1'b0}}, 1'b1};
          j_d    = '0;
        end else begin
          j_d = j_q + SPD_W'(1);
        end
        i_d = next_i;
        if (next_i > {1'b0, end_addr_i}) end_pend_d = 1'b1;
        state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    // Divide |delta*j| by N on magnitudes so the quotient truncates toward zero
    if (load_div) begin
      delta = {s1_d[DATA_W-1], s1_d} - {s0_d[DATA_W-1], s0_d};
      prod  = $signed({{SPD_W{delta[DATA_W]}}, delta}) * $signed({{(DATA_W+1){1'b0}}, j_q});
      neg_d = prod[DIV_W-1];
      quo_d = prod[DIV_W-1] ? -prod : prod;
      rem_d = '0;
      cnt_d = '0;
    end

    if (sample_tick_i && (state_q inside {S_RD0, S_RD1, S_DIV, S_CALC})) underrun_d = 1'b1;

    if (start_i) begin
      state_d     = S_PLAY;
      i_d         = '0;
      j_d         = '0;
      underrun_d  = 1'b0;
      mem_req_d   = 1'b0;
      end_pend_d  = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
    if (stop_i) begin
      state_d      = S_IDLE;
      i_d          = '0;
      j_d          = '0;
      mem_req_d    = 1'b0;
      end_pend_d   = 1'b0;
      out_sample_d = '0;
      out_valid_d  = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk50_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      n_q          <= SPD_W'(1);
      fast_q       <= 1'b0;
      interp_q     <= 1'b0;
      neg_q        <= 1'b0;
      s0_q         <= '0;
      s1_q         <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      end_pend_q   <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      n_q          <= n_d;
      fast_q       <= fast_d;
      interp_q     <= interp_d;
      neg_q        <= neg_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      end_pend_q   <= end_pend_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign out_sample_o = out_sample_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_playback_rate_engine.sv
// Randomized scoreboard bench for playback_rate_engine against an arithmetic playback model.
module tb_playback_rate_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, pause, fast, interp, sample_tick, mem_ack;
  logic [3:0]  speed;
  logic [17:0] end_addr, mem_addr;
  logic [15:0] mem_data, out_sample;
  logic        mem_req, out_valid, busy, done, underrun;

  playback_rate_engine dut (
    .clk50_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
    .fast_i(fast), .speed_i(speed), .interp_i(interp), .end_addr_i(end_addr),
    .sample_tick_i(sample_tick), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_data_i(mem_data), .out_sample_o(out_sample),
    .out_valid_o(out_valid), .busy_o(busy), .done_o(done), .underrun_o(underrun)
  );

  always #10 clk = ~clk;

  typedef struct { int val; bit last; } exp_t;
  exp_t exp_q[$];
  int   addr_q[$];
  int   mem [0:63];
  int   checks = 0, errors = 0, out_cnt = 0;
  bit   done_exp = 1'b0, auto_ack = 1'b1;
  int   mi, mj, mn, mend;
  bit   mfast, minterp, mactive;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic fail_line(input string name, input int got, input int want);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // Reference: one output per accepted tick, from position/phase arithmetic
  function automatic void model_step();
    int a, b, o;
    if (mj == 0) begin
      mfast   = fast;
      minterp = interp;
      mn      = (speed == 4'd0) ? 1 : int'(speed);
      addr_q.push_back(mi);
      if (!mfast && minterp && mi != mend) addr_q.push_back(mi + 1);
    end
    a = mem[mi];
    if (mfast) begin
      o  = a;
      mi = mi + mn;
    end else begin
      if (minterp) begin
        b = (mi == mend) ? a : mem[mi + 1];
        o = a + ((b - a) * mj) / mn;
      end else begin
        o = a;
      end
      mj++;
      if (mj == mn) begin
        mj = 0;
        mi++;
      end
    end
    exp_q.push_back('{val: o, last: (mi > mend)});
    if (mi > mend) mactive = 1'b0;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (done_exp) begin
        chk("done_pulse", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        done_exp = 1'b0;
      end else if (done) begin
        fail_line("spurious_done", int'(done), 0);
      end
      if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          fail_line("spurious_out_valid", int'($signed(out_sample)), 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_sample", int'($signed(out_sample)), e.val);
          if (e.last) done_exp = 1'b1;
        end
      end
    end
  endtask

  task automatic responder();
    int dly = 0, cnt = 0;
    bit active = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_ack) begin
        active = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        active  = 1'b0;
      end else if (!mem_req) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          dly    = int'($urandom_range(0, 3));
          cnt    = 0;
        end
        if (cnt >= dly) begin
          mem_ack  = 1'b1;
          mem_data = 16'(mem[mem_addr[5:0]]);
          if (addr_q.size() == 0) fail_line("mem_addr_unexpected", int'(mem_addr), -1);
          else chk("mem_addr", int'(mem_addr), addr_q.pop_front());
        end else begin
          cnt++;
        end
      end
    end
  endtask

  task automatic flush();
    exp_q.delete();
    addr_q.delete();
    done_exp = 1'b0;
  endtask

  task automatic set_mode(input bit f, input int sp, input bit it);
    fast   = f;
    speed  = 4'(sp);
    interp = it;
  endtask

  task automatic pulse_start(input int e);
    @(negedge clk);
    start    = 1'b1;
    end_addr = 18'(e);
    mi = 0; mj = 0; mn = 1; mend = e; mactive = 1'b1;
    flush();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    flush();
  endtask

  task automatic do_tick(input bit expect_out);
    @(negedge clk);
    sample_tick = 1'b1;
    if (expect_out) model_step();
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_out(input int base);
    bit got = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (out_cnt > base) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) fail_line("out_valid_timeout", out_cnt, base + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic tick_wait();
    int base = out_cnt;
    do_tick(1'b1);
    wait_out(base);
  endtask

  task automatic play(input int max_ticks, input bit rnd);
    int n = 0;
    while (mactive && n < max_ticks) begin
      if (rnd && $urandom_range(0, 3) == 0)
        set_mode(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      tick_wait();
      n++;
    end
    chk("busy_after_play", int'(busy), mactive ? 1 : 0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_line("mem_req_timeout", 0, 1);
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) mem[k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int base;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; fast = 1'b0; interp = 1'b0;
    sample_tick = 1'b0; mem_ack = 1'b0; speed = 4'd1; end_addr = '0; mem_data = '0;
    for (int k = 0; k < 64; k++) mem[k] = 0;
    fork
      monitor();
      responder();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fast x1 through four samples
    mem[0] = 100; mem[1] = 200; mem[2] = 300; mem[3] = 400;
    set_mode(1'b1, 1, 1'b0);
    pulse_start(3);
    chk("busy_after_start", int'(busy), 1);
    play(10, 1'b0);

    // Fast x2 reads only even addresses
    for (int k = 0; k < 5; k++) mem[k] = k;
    set_mode(1'b1, 2, 1'b0);
    pulse_start(4);
    play(10, 1'b0);

    // Slow /4 interpolation, last sample held with zero delta
    mem[0] = 0; mem[1] = 100;
    set_mode(1'b0, 4, 1'b1);
    pulse_start(1);
    play(20, 1'b0);

    // Negative slope truncates toward zero
    mem[0] = 0; mem[1] = -100;
    set_mode(1'b0, 3, 1'b1);
    pulse_start(1);
    play(20, 1'b0);

    // Pause freezes position and silences output
    fill_random(5);
    set_mode(1'b0, 3, 1'b0);
    pulse_start(4);
    play(4, 1'b0);
    pause = 1'b1;
    repeat (2) @(negedge clk);
    chk("pause_out_zero", int'(out_sample), 0);
    repeat (5) begin
      do_tick(1'b0);
      repeat (8) @(negedge clk);
    end
    chk("pause_out_still_zero", int'(out_sample), 0);
    chk("pause_busy", int'(busy), 1);
    pause = 1'b0;
    @(negedge clk);
    play(40, 1'b0);

    // STOP while the second interpolation read is pending, then a late ack
    fill_random(4);
    set_mode(1'b0, 2, 1'b1);
    auto_ack = 1'b0;
    pulse_start(3);
    do_tick(1'b0);
    wait_req(ok);
    chk("rd0_addr", int'(mem_addr), 0);
    mem_ack = 1'b1; mem_data = 16'(mem[0]);
    @(negedge clk);
    mem_ack = 1'b0;
    wait_req(ok);
    chk("rd1_addr", int'(mem_addr), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    flush();
    chk("stop_mem_req", int'(mem_req), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_out_sample", int'(out_sample), 0);
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_data = 16'(mem[1]);
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (40) @(negedge clk);
    chk("late_ack_busy", int'(busy), 0);
    chk("late_ack_mem_req", int'(mem_req), 0);
    auto_ack = 1'b1;

    // Second tick while still computing is dropped and flagged
    fill_random(4);
    set_mode(1'b0, 4, 1'b1);
    pulse_start(3);
    chk("underrun_clear_pre", int'(underrun), 0);
    base = out_cnt;
    do_tick(1'b1);
    repeat (9) @(negedge clk);
    do_tick(1'b0);
    wait_out(base);
    chk("underrun_set", int'(underrun), 1);
    play(3, 1'b0);
    chk("underrun_sticky", int'(underrun), 1);
    pulse_start(3);
    chk("underrun_cleared", int'(underrun), 0);
    pulse_stop();

    // Restart mid-play returns to address 0
    fill_random(9);
    set_mode(1'b0, 2, 1'b1);
    pulse_start(8);
    play(3, 1'b0);
    pulse_start(8);
    play(40, 1'b0);

    // Random sources and modes, including N=0 and mid-play mode changes
    for (int r = 0; r < 6; r++) begin
      fill_random(11);
      set_mode(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      pulse_start(int'($urandom_range(0, 10)));
      play(200, 1'b1);
    end

    // Asynchronous reset drops the request without waiting for a clock edge
    auto_ack = 1'b0;
    set_mode(1'b1, 1, 1'b0);
    pulse_start(5);
    do_tick(1'b0);
    wait_req(ok);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", int'(mem_req), 0);
    chk("async_rst_busy", int'(busy), 0);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    auto_ack = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
